// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider (ratio 2..2^CNT_W-1)
// with a req/ack ratio-change handshake applied only at a divided-period
// boundary, and a glitch-free switch between refclk and the divided clock.
// Optional feature macro: CLK_DIV_PROG_EDGE_PULSE_EN adds div_rise/div_fall,
// one-cycle refclk pulses aligned with the rising/falling edge of the raw clock.
module clk_div_prog #(
    parameter int CNT_W        = 8,
    parameter int DIV_RST      = 8,
    parameter bit WITH_CLK_MUX = 1'b1
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             divclk_sel,
    input  logic             dft_en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_req,
    output logic             div_ack,
    output logic             div_busy,
    output logic [CNT_W-1:0] cur_div,
`ifdef CLK_DIV_PROG_EDGE_PULSE_EN
    output logic             div_rise,
    output logic             div_fall,
`endif
    output logic             divclk
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pend;
    logic             raw;

    logic             running;
    logic             div_ge2;
    logic [CNT_W-1:0] high_len;
    logic             cnt_last;
    logic             apply;
    logic [CNT_W-1:0] val_fix;
    logic             raw_d;
    logic             sel;

    // Counter runs in functional mode or whenever scan/DFT forces it.
    assign running  = dft_en | divclk_sel;
    // Ratio 1 is the bypass ratio: no divided clock is produced.
    assign div_ge2  = (cur_div > CNT_W'(1));
    // High phase is the larger half, so odd ratios are high one cycle longer.
    assign high_len = cur_div - (cur_div >> 1);
    assign cnt_last = (cnt == cur_div - CNT_W'(1));
    // A pending ratio lands at a period boundary, or at once when stopped.
    assign apply    = (state == ST_PEND) & (~running | cnt_last);
    assign val_fix  = (div_val < CNT_W'(2)) ? CNT_W'(1) : div_val;
    assign raw_d    = running & div_ge2 & (cnt < high_len);
    assign sel      = ~dft_en & divclk_sel & div_ge2;

    assign div_busy = (state == ST_PEND);

    // Period counter and registered raw divided clock.
    always_ff @(posedge refclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, regardless of statement order.
        if (!rst_n) begin
            cnt <= '0;
            raw <= 1'b0;
        end else begin
            raw <= raw_d;
            if (apply || !running || cnt_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Ratio-change handshake: latch in IDLE, apply at the boundary in PEND.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pend    <= CNT_W'(1);
            cur_div <= CNT_W'(DIV_RST);
            div_ack <= 1'b0;
        end else begin
            div_ack <= apply;
            if (apply) begin
                cur_div <= pend;
                state   <= ST_IDLE;
            end else if (state == ST_IDLE && div_req) begin
                pend  <= val_fix;
                state <= ST_PEND;
            end
        end
    end

`ifdef CLK_DIV_PROG_EDGE_PULSE_EN
    // Edge pulses registered alongside raw so they line up with its edges.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            div_rise <= 1'b0;
            div_fall <= 1'b0;
        end else begin
            div_rise <= raw_d & ~raw;
            div_fall <= running & ~raw_d & raw;
        end
    end
`endif

    generate
        if (WITH_CLK_MUX) begin : g_mux
            logic en_ref;
            logic en_div;

            // Break-before-make enables, updated while refclk is low. The
            // divided side only changes while raw is low, so neither leg of
            // the OR can be cut or started mid-pulse.
            always_ff @(negedge refclk) begin
                if (!rst_n) begin
                    en_ref <= 1'b1;
                    en_div <= 1'b0;
                end else begin
                    en_ref <= ~sel & ~en_div;
                    if (!raw) begin
                        en_div <= sel & ~en_ref;
                    end
                end
            end

            assign divclk = (refclk & en_ref) | (raw & en_div);
        end else begin : g_nomux
            logic unused_sel;
            assign unused_sel = sel;
            assign divclk     = raw;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed handshake/ratio scenarios with
// literal expectations, then randomized stimulus checked every cycle against a
// behavioural model of the divider. Honors CLK_DIV_PROG_EDGE_PULSE_EN.
module tb_clk_div_prog;

    localparam int CNT_W   = 8;
    localparam int DIV_RST = 8;

    logic             refclk;
    logic             rst_n;
    logic             divclk_sel;
    logic             dft_en;
    logic [CNT_W-1:0] div_val;
    logic             div_req;
    logic             div_ack;
    logic             div_busy;
    logic [CNT_W-1:0] cur_div;
    logic             divclk;
`ifdef CLK_DIV_PROG_EDGE_PULSE_EN
    logic             div_rise;
    logic             div_fall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: ratio, position inside the current period, request.
    int m_n;
    int m_phase;
    int m_pend;
    int m_stable;
    bit m_busy;
    bit m_ack;
    bit m_raw;
    bit m_rise;
    bit m_fall;
    bit m_sel;
    bit m_last_sel;

    clk_div_prog #(
        .CNT_W       (CNT_W),
        .DIV_RST     (DIV_RST),
        .WITH_CLK_MUX(1'b1)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .divclk_sel(divclk_sel),
        .dft_en    (dft_en),
        .div_val   (div_val),
        .div_req   (div_req),
        .div_ack   (div_ack),
        .div_busy  (div_busy),
        .cur_div   (cur_div),
`ifdef CLK_DIV_PROG_EDGE_PULSE_EN
        .div_rise  (div_rise),
        .div_fall  (div_fall),
`endif
        .divclk    (divclk)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One refclk rising edge of the model, from the divider's stated rules.
    task automatic model_step();
        int  h;
        bit  running;
        bit  raw_n;
        if (!rst_n) begin
            m_n     = DIV_RST;
            m_phase = 0;
            m_busy  = 0;
            m_ack   = 0;
            m_raw   = 0;
            m_rise  = 0;
            m_fall  = 0;
        end else begin
            running = dft_en | divclk_sel;
            h       = m_n - m_n / 2;
            raw_n   = running && (m_n >= 2) && (m_phase < h);
            m_rise  = raw_n && !m_raw;
            m_fall  = running && !raw_n && m_raw;
            m_raw   = raw_n;
            m_ack   = 0;
            if (m_busy && (!running || m_phase == m_n - 1)) begin
                m_n     = m_pend;
                m_phase = 0;
                m_busy  = 0;
                m_ack   = 1;
            end else begin
                m_phase = running ? (m_phase + 1) % m_n : 0;
                if (!m_busy && div_req) begin
                    m_pend = (int'(div_val) < 2) ? 1 : int'(div_val);
                    m_busy = 1;
                end
            end
        end
        m_sel = !dft_en && divclk_sel && (m_n >= 2);
        if (!rst_n || m_sel != m_last_sel) m_stable = 0;
        else if (m_stable < 100000) m_stable++;
        m_last_sel = m_sel;
    endtask

    // Compare process: model advances on each rising edge; outputs sampled
    // 1 time unit after each refclk edge (refclk high, then refclk low).
    always begin
        @(posedge refclk);
        model_step();
        #1;
        check("cur_div", cur_div, m_n);
        check("div_busy", div_busy, m_busy);
        check("div_ack", div_ack, m_ack);
`ifdef CLK_DIV_PROG_EDGE_PULSE_EN
        check("div_rise", div_rise, m_rise);
        check("div_fall", div_fall, m_fall);
`endif
        if (m_stable > 2 * m_n + 4) check("divclk_hi", divclk, m_sel ? m_raw : 1'b1);
        @(negedge refclk);
        #1;
        if (m_stable > 2 * m_n + 4) check("divclk_lo", divclk, m_sel ? m_raw : 1'b0);
    end

    // Advance to 8 units after the next rising edge: the drive/read point.
    task automatic tick();
        @(posedge refclk);
        #8;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pulse a request for one cycle and return cycles until div_ack.
    task automatic req_ratio(input int v, output int lat);
        bit seen;
        seen    = 0;
        lat     = 0;
        div_val = CNT_W'(v);
        div_req = 1'b1;
        for (int i = 1; i <= 600 && !seen; i++) begin
            tick();
            div_req = 1'b0;
            if (div_ack) begin
                seen = 1;
                lat  = i;
            end
        end
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
    endtask

    // Count high samples and 0->1 transitions of divclk while refclk is low.
    task automatic measure(input int cycles, output int highs, output int rises);
        logic prev;
        highs = 0;
        rises = 0;
        prev  = divclk;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (divclk === 1'b1) highs++;
            if (divclk === 1'b1 && prev === 1'b0) rises++;
            prev = divclk;
        end
    endtask

    initial begin
        int lat;
        int highs;
        int rises;
        int k;
        int acks;

        rst_n      = 1'b0;
        divclk_sel = 1'b1;
        dft_en     = 1'b0;
        div_req    = 1'b0;
        div_val    = '0;
        ticks(4);
        check("rst_cur_div", cur_div, 32'd8);
        check("rst_busy", div_busy, 32'd0);
        check("rst_ack", div_ack, 32'd0);

        // Reset ratio 8: period 8, high 4.
        rst_n = 1'b1;
        ticks(24);
        measure(16, highs, rises);
        check("n8_highs", highs, 32'd8);
        check("n8_rises", rises, 32'd2);

        // Handshake: request 3 while cnt==2 of the first N=8 period.
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
        div_val = 8'd3;
        div_req = 1'b1;
        lat = 0;
        for (k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) begin
                check("hs_busy", div_busy, 32'd1);
                div_val = 8'd9;
            end
            if (k == 5) div_req = 1'b0;
            if (div_ack) begin
                lat = k;
                break;
            end
        end
        div_req = 1'b0;
        check("hs_latency", lat, 32'd6);
        check("hs_cur_div", cur_div, 32'd3);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (div_ack) acks++;
        end
        check("hs_single_ack", acks, 32'd0);
        measure(15, highs, rises);
        check("n3_highs", highs, 32'd10);
        check("n3_rises", rises, 32'd5);

        // Odd ratio 5: high 3, low 2.
        req_ratio(5, lat);
        check("n5_cur_div", cur_div, 32'd5);
        ticks(3);
        measure(15, highs, rises);
        check("n5_highs", highs, 32'd9);
        check("n5_rises", rises, 32'd3);

        // Ratios 0 and 1 both mean bypass; then divide by 2.
        req_ratio(0, lat);
        check("v0_cur_div", cur_div, 32'd1);
        ticks(10);
        req_ratio(1, lat);
        check("v1_cur_div", cur_div, 32'd1);
        ticks(10);
        req_ratio(2, lat);
        check("v2_cur_div", cur_div, 32'd2);
        ticks(10);
        measure(16, highs, rises);
        check("n2_highs", highs, 32'd8);
        check("n2_rises", rises, 32'd8);

        // Stopped counter: ack two cycles after the request.
        divclk_sel = 1'b0;
        ticks(3);
        req_ratio(7, lat);
        check("stopped_latency", lat, 32'd2);
        check("stopped_cur_div", cur_div, 32'd7);

        // DFT: counter runs, output is refclk, request waits for a boundary.
        dft_en = 1'b1;
        ticks(20);
        req_ratio(6, lat);
        check("dft_lat_in_range", (lat >= 2 && lat <= 8), 32'd1);
        check("dft_cur_div", cur_div, 32'd6);
        ticks(10);

        // Reset while a request is pending discards it.
        dft_en     = 1'b0;
        divclk_sel = 1'b1;
        ticks(3);
        div_val = 8'd4;
        div_req = 1'b1;
        tick();
        div_req = 1'b0;
        check("pend_busy", div_busy, 32'd1);
        rst_n = 1'b0;
        tick();
        check("pend_rst_busy", div_busy, 32'd0);
        check("pend_rst_ack", div_ack, 32'd0);
        check("pend_rst_cur_div", cur_div, 32'd8);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (div_ack) acks++;
        end
        check("pend_rst_no_ack", acks, 32'd0);

`ifdef CLK_DIV_PROG_EDGE_PULSE_EN
        // Edge pulses at N=4: one rise and one fall per period.
        req_ratio(4, lat);
        ticks(8);
        highs = 0;
        rises = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (div_rise) rises++;
            if (div_fall) highs++;
        end
        check("n4_rise_pulses", rises, 32'd4);
        check("n4_fall_pulses", highs, 32'd4);
`endif

        // Randomized segments checked by the compare process.
        for (int s = 0; s < 400; s++) begin
            int hold;
            hold       = $urandom_range(1, 12);
            rst_n      = ($urandom_range(0, 40) != 0);
            divclk_sel = ($urandom_range(0, 4) != 0);
            dft_en     = ($urandom_range(0, 5) == 0);
            div_val    = ($urandom_range(0, 15) == 0) ? CNT_W'($urandom_range(0, 255))
                                                      : CNT_W'($urandom_range(0, 12));
            div_req    = ($urandom_range(0, 2) == 0);
            for (int c = 0; c < hold; c++) begin
                tick();
                if (c == 0 && $urandom_range(0, 1) == 1) div_req = 1'b0;
            end
        end

        rst_n      = 1'b1;
        div_req    = 1'b0;
        divclk_sel = 1'b1;
        dft_en     = 1'b0;
        ticks(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
